// File: rtl/matrix_inverse_5x5.sv
// Exact 5x5 integer inverter: fraction-free Gauss-Jordan (Bareiss) on [A | I], one row per cycle.
// Produces adj(A) and the leading principal minors; pivot5 = det(A).
module matrix_inverse_5x5 #(
  parameter int W  = 32,
  parameter int IW = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a11, a12, a13, a14, a15,
  input  logic [W-1:0] a21, a22, a23, a24, a25,
  input  logic [W-1:0] a31, a32, a33, a34, a35,
  input  logic [W-1:0] a41, a42, a43, a44, a45,
  input  logic [W-1:0] a51, a52, a53, a54, a55,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] i11, i12, i13, i14, i15,
  output logic [W-1:0] i21, i22, i23, i24, i25,
  output logic [W-1:0] i31, i32, i33, i34, i35,
  output logic [W-1:0] i41, i42, i43, i44, i45,
  output logic [W-1:0] i51, i52, i53, i54, i55,
  output logic [W-1:0] pivot1, pivot2, pivot3, pivot4, pivot5
);

  localparam int PW = 2 * IW;

  typedef enum logic {IDLE, ELIM} state_t;

  state_t                state, state_n;
  logic [0:24][W-1:0]    ain;
  logic [0:24][W-1:0]    ireg;
  logic [0:4][W-1:0]     preg;
  logic [0:4][W-1:0]     piv;
  logic signed [IW-1:0]  m [5][10];
  logic signed [IW-1:0]  newrow [10];
  logic signed [IW-1:0]  prev;
  logic signed [IW-1:0]  kk;
  logic signed [PW-1:0]  num;
  logic [2:0]            k;
  logic [2:0]            i;
  logic                  pivzero;
  logic                  last;

  assign ain = {a11, a12, a13, a14, a15, a21, a22, a23, a24, a25,
                a31, a32, a33, a34, a35, a41, a42, a43, a44, a45,
                a51, a52, a53, a54, a55};
  assign {i11, i12, i13, i14, i15, i21, i22, i23, i24, i25,
          i31, i32, i33, i34, i35, i41, i42, i43, i44, i45,
          i51, i52, i53, i54, i55} = ireg;
  assign {pivot1, pivot2, pivot3, pivot4, pivot5} = preg;

  assign busy    = (state == ELIM);
  assign kk      = m[k][k];
  assign pivzero = (kk == '0);
  assign last    = (k == 3'd4) && (i == 3'd4);

  // Products of two k-minors can exceed IW bits, so they are formed at 2*IW before the exact divide.
  always_comb begin
    num = '0;
    for (int j = 0; j < 10; j++) begin
      num       = PW'(kk) * PW'(m[i][j]) - PW'(m[i][k]) * PW'(m[k][j]);
      newrow[j] = IW'(num / PW'(prev));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = ELIM;
      ELIM:    if (((i == k) && pivzero) || last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 10; c++)
          m[r][c] <= '0;
      prev <= IW'(1);
      k    <= '0;
      i    <= '0;
      piv  <= '0;
      ireg <= '0;
      preg <= '0;
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) begin
              m[r][c]   <= IW'($signed(ain[r*5+c]));
              m[r][c+5] <= (r == c) ? IW'(1) : '0;
            end
          prev <= IW'(1);
          k    <= '0;
          i    <= '0;
          err  <= 1'b0;
        end
      end else begin
        if (i == k) begin
          if (pivzero) begin
            err  <= 1'b1;
            done <= 1'b1;
            ireg <= '0;
            preg <= '0;
          end else begin
            piv[k] <= kk[W-1:0];
            // On the final pivot row every other row is already fully reduced.
            if (last) begin
              for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++)
                  ireg[r*5+c] <= m[r][c+5][W-1:0];
              preg <= {piv[0], piv[1], piv[2], piv[3], kk[W-1:0]};
              done <= 1'b1;
            end
          end
        end else begin
          for (int j = 0; j < 10; j++)
            m[i][j] <= newrow[j];
        end
        if (i == 3'd4) begin
          i    <= '0;
          prev <= kk;
          if (!last) k <= k + 3'd1;
        end else begin
          i <= i + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_inverse_5x5.sv
// Bench for matrix_inverse_5x5: a cofactor/Leibniz determinant model predicts adj, minors and timing.
module tb_matrix_inverse_5x5;
  localparam int W = 32;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a  [25];
  logic [W-1:0] iv [25];
  logic [W-1:0] pv [5];
  logic         busy, done, err;

  int      vectors     = 0;
  int      miscompares = 0;
  bit      checking    = 1'b0;
  longint  mat [5][5];

  bit           m_busy, m_done, m_err;
  int           m_cnt;
  bit [W-1:0]   m_i [25];
  bit [W-1:0]   m_p [5];
  bit           p_err;
  int           p_end;
  bit [W-1:0]   p_i [25];
  bit [W-1:0]   p_p [5];

  always #5 clk = ~clk;

  matrix_inverse_5x5 dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a11(a[0]),  .a12(a[1]),  .a13(a[2]),  .a14(a[3]),  .a15(a[4]),
    .a21(a[5]),  .a22(a[6]),  .a23(a[7]),  .a24(a[8]),  .a25(a[9]),
    .a31(a[10]), .a32(a[11]), .a33(a[12]), .a34(a[13]), .a35(a[14]),
    .a41(a[15]), .a42(a[16]), .a43(a[17]), .a44(a[18]), .a45(a[19]),
    .a51(a[20]), .a52(a[21]), .a53(a[22]), .a54(a[23]), .a55(a[24]),
    .busy(busy), .done(done), .err(err),
    .i11(iv[0]),  .i12(iv[1]),  .i13(iv[2]),  .i14(iv[3]),  .i15(iv[4]),
    .i21(iv[5]),  .i22(iv[6]),  .i23(iv[7]),  .i24(iv[8]),  .i25(iv[9]),
    .i31(iv[10]), .i32(iv[11]), .i33(iv[12]), .i34(iv[13]), .i35(iv[14]),
    .i41(iv[15]), .i42(iv[16]), .i43(iv[17]), .i44(iv[18]), .i45(iv[19]),
    .i51(iv[20]), .i52(iv[21]), .i53(iv[22]), .i54(iv[23]), .i55(iv[24]),
    .pivot1(pv[0]), .pivot2(pv[1]), .pivot3(pv[2]), .pivot4(pv[3]), .pivot5(pv[4])
  );

  // Leibniz determinant of the top-left n x n block: sum over permutations of signed products.
  function automatic longint det(input longint mm [5][5], input int n);
    longint sum, prod;
    int     p [5];
    int     total, code, inv;
    bit     ok;
    sum   = 0;
    total = 1;
    for (int t = 0; t < n; t++) total *= n;
    for (int t = 0; t < total; t++) begin
      code = t;
      ok   = 1'b1;
      inv  = 0;
      prod = 1;
      for (int r = 0; r < n; r++) begin
        p[r] = code % n;
        code = code / n;
      end
      for (int r = 0; r < n; r++)
        for (int s = r + 1; s < n; s++) begin
          if (p[r] == p[s]) ok = 1'b0;
          if (p[r] > p[s]) inv++;
        end
      if (ok) begin
        for (int r = 0; r < n; r++) prod *= mm[r][p[r]];
        sum += (inv % 2 == 1) ? -prod : prod;
      end
    end
    return sum;
  endfunction

  function automatic void modelInverse(input longint aa [5][5]);
    longint sub [5][5];
    longint d;
    p_err = 1'b0;
    p_end = 25;
    for (int k = 1; k <= 5; k++) begin
      d = det(aa, k);
      p_p[k-1] = W'(d);
      if (d == 0 && !p_err) begin
        p_err = 1'b1;
        p_end = (k - 1) * 5 + k;
      end
    end
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        for (int rr = 0; rr < 4; rr++)
          for (int cc = 0; cc < 4; cc++)
            sub[rr][cc] = aa[(rr < c) ? rr : rr + 1][(cc < r) ? cc : cc + 1];
        d = det(sub, 4);
        if ((r + c) % 2 == 1) d = -d;
        p_i[r*5+c] = W'(d);
      end
    if (p_err) begin
      for (int t = 0; t < 25; t++) p_i[t] = '0;
      for (int t = 0; t < 5; t++) p_p[t] = '0;
    end
  endfunction

  // Cycle-level expectation: results appear p_end edges after the accepting edge.
  always @(posedge clk or negedge rst_n) begin : model
    longint aa [5][5];
    if (!rst_n) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_err  = 1'b0;
      m_cnt  = 0;
      for (int t = 0; t < 25; t++) m_i[t] = '0;
      for (int t = 0; t < 5; t++) m_p[t] = '0;
    end else begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (start) begin
          for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
              aa[r][c] = longint'($signed(a[r*5+c]));
          modelInverse(aa);
          m_busy = 1'b1;
          m_cnt  = 0;
          m_err  = 1'b0;
        end
      end else begin
        m_cnt++;
        if (m_cnt == p_end) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_err  = p_err;
          for (int t = 0; t < 25; t++) m_i[t] = p_i[t];
          for (int t = 0; t < 5; t++) m_p[t] = p_p[t];
        end
      end
    end
  end

  task automatic checkValue(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", nm, act, expv);
    end
  endtask

  task automatic checkOutput();
    checkValue("busy", W'(busy), W'(m_busy));
    checkValue("done", W'(done), W'(m_done));
    checkValue("err",  W'(err),  W'(m_err));
    for (int t = 0; t < 25; t++)
      checkValue($sformatf("i%0d%0d", t / 5 + 1, t % 5 + 1), iv[t], m_i[t]);
    for (int t = 0; t < 5; t++)
      checkValue($sformatf("pivot%0d", t + 1), pv[t], m_p[t]);
  endtask

  always @(negedge clk) if (checking) checkOutput();

  task automatic setDiag(input longint d);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        mat[r][c] = (r == c) ? d : 0;
  endtask

  task automatic randomFill(input int lim);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        mat[r][c] = longint'($urandom_range(2 * lim)) - lim;
  endtask

  task automatic loadMatrix();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        a[r*5+c] = W'(mat[r][c]);
  endtask

  task automatic waitDone();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL done_timeout: got no done pulse, expected one within 60 cycles");
    end
  endtask

  task automatic applyStimulus();
    loadMatrix();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    waitDone();
  endtask

  // Called in the done cycle: the new start lands on the edge where the engine is idle again.
  task automatic applyBackToBack();
    loadMatrix();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    waitDone();
  endtask

  initial begin
    longint sum;
    for (int t = 0; t < 25; t++) a[t] = '0;

    setDiag(1);
    modelInverse(mat);
    checkValue("model I pivot5", p_p[4], 32'd1);
    checkValue("model I i11", p_i[0], 32'd1);
    checkValue("model I i12", p_i[1], 32'd0);
    setDiag(2);
    modelInverse(mat);
    checkValue("model 2I pivot3", p_p[2], 32'd8);
    checkValue("model 2I pivot5", p_p[4], 32'd32);
    checkValue("model 2I i33", p_i[12], 32'd16);
    setDiag(1);
    mat[0][1] = 3;
    modelInverse(mat);
    checkValue("model a12=3 i12", p_i[1], 32'hFFFFFFFD);
    checkValue("model a12=3 i21", p_i[5], 32'd0);
    setDiag(1);
    mat[0][0] = 0;
    modelInverse(mat);
    checkValue("model a11=0 err", W'(p_err), 32'd1);
    checkValue("model a11=0 latency", W'(p_end), 32'd1);
    mat = '{'{5, 3, 1, 7, 9}, '{6, 4, 2, 8, -8}, '{7, 5, 3, 10, 9},
            '{9, 6, 4, -9, -5}, '{8, 5, 2, 11, 4}};
    modelInverse(mat);
    if (!p_err)
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++) begin
          sum = 0;
          for (int t = 0; t < 5; t++) sum += mat[r][t] * longint'($signed(p_i[t*5+c]));
          checkValue($sformatf("model AxAdj %0d%0d", r + 1, c + 1), W'(sum),
                     W'((r == c) ? det(mat, 5) : 0));
        end

    repeat (2) @(posedge clk);
    #1 checking = 1'b1;
    checkOutput();
    rst_n = 1'b1;

    setDiag(1);           applyStimulus();
    setDiag(2);           applyStimulus();
    setDiag(1); mat[0][1] = 3; applyStimulus();
    setDiag(1); mat[0][0] = 0; applyStimulus();
    mat = '{'{5, 3, 1, 7, 9}, '{6, 4, 2, 8, -8}, '{7, 5, 3, 10, 9},
            '{9, 6, 4, -9, -5}, '{8, 5, 2, 11, 4}};
    applyStimulus();

    randomFill(8);        applyBackToBack();
    setDiag(1); mat[0][0] = 0; applyBackToBack();
    setDiag(3);           applyBackToBack();

    randomFill(9);
    loadMatrix();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 randomFill(9);
    loadMatrix();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    waitDone();

    for (int n = 0; n < 12; n++) begin
      randomFill(8);
      if (n % 4 == 3)
        for (int c = 0; c < 5; c++) mat[(n / 4) + 1][c] = mat[0][c];
      applyStimulus();
    end
    for (int n = 0; n < 3; n++) begin
      randomFill(128);
      applyStimulus();
    end

    randomFill(7);
    loadMatrix();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 checkOutput();
    checkValue("reset busy", W'(busy), 32'd0);
    checkValue("reset pivot5", pv[4], 32'd0);
    checkValue("reset i11", iv[0], 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    setDiag(1); mat[2][4] = -5; applyStimulus();
    repeat (3) @(posedge clk);
    #1 checking = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
